atm_keypad_entry: RTL

ATM_KEYPAD_ENTRY -- requirements
Module: atm_keypad_entry

---
 rtl/atm_keypad_entry.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/atm_keypad_entry.sv
// ATM keypad entry controller: collects an account digit and a 4-digit PIN,
// offers them downstream, tracks authentication failures and locks out after
// too many failed attempts on one card.
module atm_keypad_entry #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned MAX_ATTEMPTS   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        card_in,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        entry_ready,
  input  logic        auth_ok,
  input  logic        auth_fail,
  output logic [3:0]  acc_num,
  output logic [15:0] pin,
  output logic        entry_valid,
  output logic        key_error,
  output logic        locked,
  output logic [2:0]  state,
  output logic [2:0]  digit_count
);

  localparam int unsigned TimeoutW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned AttemptW = (MAX_ATTEMPTS > 0) ? $clog2(MAX_ATTEMPTS + 1) : 1;
  localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT_CYCLES - 1);
  localparam logic [AttemptW-1:0] AttemptMax  = AttemptW'(MAX_ATTEMPTS);

  localparam logic [3:0] KeyEnter  = 4'hA;
  localparam logic [3:0] KeyClear  = 4'hB;
  localparam logic [3:0] KeyCancel = 4'hC;

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StAcc        = 3'd1,
    StPin        = 3'd2,
    StPresent    = 3'd3,
    StWaitResult = 3'd4,
    StDone       = 3'd5,
    StLocked     = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic                card_q;
  logic [3:0]          acc_q, acc_d;
  logic                loaded_q, loaded_d;
  logic [15:0]         pin_q, pin_d;
  logic [2:0]          dc_q, dc_d;
  logic [AttemptW-1:0] attempt_q, attempt_d;
  logic [AttemptW-1:0] attempt_inc;
  logic [TimeoutW-1:0] timeout_q, timeout_d;
  logic                key_error_q, key_error_d;

  logic in_entry;
  logic key_acc;
  logic clear_data;
  logic clear_attempt;

  assign in_entry = (state_q == StAcc) || (state_q == StPin);

  // Next-state, datapath and counter updates.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    loaded_d      = loaded_q;
    pin_d         = pin_q;
    dc_d          = dc_q;
    attempt_d     = attempt_q;
    key_error_d   = 1'b0;
    key_acc       = 1'b0;
    clear_data    = 1'b0;
    clear_attempt = 1'b0;
    attempt_inc   = (attempt_q < AttemptMax) ? attempt_q + AttemptW'(1) : AttemptMax;

    case (state_q)
      StIdle: begin
        if (card_in && !card_q) state_d = StAcc;
      end

      StAcc, StPin: begin
        if (!card_in) begin
          state_d       = StIdle;
          clear_data    = 1'b1;
          clear_attempt = 1'b1;
        end else begin
          if (key_valid) begin
            if (key_code == KeyCancel) begin
              state_d    = StIdle;
              clear_data = 1'b1;
              key_acc    = 1'b1;
            end else if (key_code == KeyClear) begin
              key_acc = 1'b1;
              if (state_q == StAcc) begin
                acc_d    = 4'd0;
                loaded_d = 1'b0;
              end else begin
                pin_d = 16'd0;
                dc_d  = 3'd0;
              end
            end else if (key_code > KeyCancel) begin
              key_error_d = 1'b1;
            end else if (state_q == StAcc) begin
              if (key_code <= 4'd9) begin
                acc_d    = key_code;
                loaded_d = 1'b1;
                key_acc  = 1'b1;
              end else if (loaded_q) begin
                state_d = StPin;
                key_acc = 1'b1;
              end else begin
                key_error_d = 1'b1;
              end
            end else begin
              if (key_code <= 4'd9) begin
                if (dc_q < 3'd4) begin
                  pin_d   = {pin_q[11:0], key_code};
                  dc_d    = dc_q + 3'd1;
                  key_acc = 1'b1;
                end else begin
                  key_error_d = 1'b1;
                end
              end else if (dc_q == 3'd4) begin
                state_d = StPresent;
                key_acc = 1'b1;
              end else begin
                key_error_d = 1'b1;
              end
            end
          end
          // An accepted key restarts the idle window, so it wins over timeout.
          if (!key_acc && timeout_q == TimeoutLast) begin
            state_d    = StIdle;
            clear_data = 1'b1;
          end
        end
      end

      StPresent: begin
        if (!card_in) begin
          state_d       = StIdle;
          clear_data    = 1'b1;
          clear_attempt = 1'b1;
        end else if (entry_ready) begin
          state_d = StWaitResult;
        end
      end

      StWaitResult: begin
        if (!card_in) begin
          state_d       = StIdle;
          clear_data    = 1'b1;
          clear_attempt = 1'b1;
        end else if (auth_fail) begin
          // Simultaneous ok/fail counts as a failure.
          attempt_d = attempt_inc;
          pin_d     = 16'd0;
          dc_d      = 3'd0;
          state_d   = (attempt_inc == AttemptMax) ? StLocked : StPin;
        end else if (auth_ok) begin
          attempt_d = '0;
          state_d   = StDone;
        end
      end

      StDone: begin
        if (!card_in) begin
          state_d       = StIdle;
          clear_data    = 1'b1;
          clear_attempt = 1'b1;
        end
      end

      StLocked: begin
        state_d = StLocked;
      end

      default: begin
        state_d    = StIdle;
        clear_data = 1'b1;
      end
    endcase

    if (clear_data) begin
      acc_d    = 4'd0;
      loaded_d = 1'b0;
      pin_d    = 16'd0;
      dc_d     = 3'd0;
    end
    if (clear_attempt) attempt_d = '0;

    if (in_entry && state_d == state_q && !key_acc) begin
      timeout_d = timeout_q + TimeoutW'(1);
    end else begin
      timeout_d = '0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      card_q      <= 1'b0;
      acc_q       <= 4'd0;
      loaded_q    <= 1'b0;
      pin_q       <= 16'd0;
      dc_q        <= 3'd0;
      attempt_q   <= '0;
      timeout_q   <= '0;
      key_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      card_q      <= card_in;
      acc_q       <= acc_d;
      loaded_q    <= loaded_d;
      pin_q       <= pin_d;
      dc_q        <= dc_d;
      attempt_q   <= attempt_d;
      timeout_q   <= timeout_d;
      key_error_q <= key_error_d;
    end
  end

  assign state       = state_q;
  assign acc_num     = acc_q;
  assign pin         = pin_q;
  assign digit_count = dc_q;
  assign key_error   = key_error_q;
  assign entry_valid = (state_q == StPresent);
  assign locked      = (state_q == StLocked);

endmodule
